// File: rtl/dfm_gate_ctl_if.sv
// Control and register-file bulk-write bundle of the frequency-meter gate sequencer.
// master: software/register-file side, slave: dfm_gate_ctl.
interface dfm_gate_ctl_if;
    logic        start_i;
    logic [31:0] gate_time_i;
    logic        busy_o;
    logic        done_o;
    logic        timeout_o;
    logic        reg_wr_en_o;
    logic [2:0]  reg_wr_addr_o;
    logic [95:0] reg_wr_data_o;

    modport master (
        output start_i, gate_time_i,
        input  busy_o, done_o, timeout_o, reg_wr_en_o, reg_wr_addr_o, reg_wr_data_o
    );

    modport slave (
        input  start_i, gate_time_i,
        output busy_o, done_o, timeout_o, reg_wr_en_o, reg_wr_addr_o, reg_wr_data_o
    );
endinterface

// File: rtl/dfm_gate_ctl.sv
// Reciprocal-counting measurement sequencer: one gated measurement per start, result
// written as {high_cnt, sig_cnt, ref_cnt} at address 3'b100. Optional watchdog: DFM_TIMEOUT_EN.
module dfm_gate_ctl #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_WIDTH   = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          sig_i,
    dfm_gate_ctl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ARM, MEAS, WRITE} state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sig_s, sig_s_d_q, sig_s_d_d, rise_s;

    logic [31:0]          gt_q, gt_d;
    logic [CNT_WIDTH-1:0] ref_q, ref_d, sig_cnt_q, sig_cnt_d, high_q, high_d;
    logic [CNT_WIDTH-1:0] ref_inc;
    logic                 close, expire, abort;

    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        timeout_q, timeout_d;
    logic        wr_en_q, wr_en_d;
    logic [2:0]  wr_addr_q, wr_addr_d;
    logic [95:0] wr_data_q, wr_data_d;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign sync_d    = {sync_q[SYNC_STAGES-2:0], sig_i};
    assign sig_s     = sync_q[SYNC_STAGES-1];
    assign sig_s_d_d = sig_s;
    assign rise_s    = sig_s & ~sig_s_d_q;

    assign ref_inc = sat_inc(ref_q);
    assign close   = (state_q == MEAS) && rise_s && (ref_inc >= gt_q);

`ifdef DFM_TIMEOUT_EN
    logic [33:0] wd_q, wd_d;

    always_comb begin
        wd_d = wd_q;
        if (state_q == IDLE) begin
            wd_d = '0;
        end else if (state_q == ARM || state_q == MEAS) begin
            wd_d = wd_q + 34'd1;
        end
    end

    // Fires on the cycle whose increment makes the watchdog equal 4*gt_q.
    assign expire = (state_q == ARM || state_q == MEAS) && ((wd_q + 34'd1) >= {gt_q, 2'b00});

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    assign expire = 1'b0;
`endif

    assign abort = expire && !close;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (bus.start_i) state_d = ARM;
            ARM: begin
                if (expire)      state_d = WRITE;
                else if (rise_s) state_d = MEAS;
            end
            MEAS:  if (close || expire) state_d = WRITE;
            WRITE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Gate latch and measurement counters
    always_comb begin
        gt_d      = gt_q;
        ref_d     = ref_q;
        sig_cnt_d = sig_cnt_q;
        high_d    = high_q;
        case (state_q)
            IDLE: begin
                if (bus.start_i) gt_d = (bus.gate_time_i == '0) ? 32'd1 : bus.gate_time_i;
            end
            ARM: begin
                if (rise_s) begin
                    ref_d     = '0;
                    sig_cnt_d = '0;
                    high_d    = '0;
                end
            end
            MEAS: begin
                ref_d = ref_inc;
                if (rise_s) sig_cnt_d = sat_inc(sig_cnt_q);
                if (sig_s)  high_d    = sat_inc(high_q);
            end
            default: ;
        endcase
    end

    // Outputs are computed from the next state so they register alongside it.
    always_comb begin
        busy_d    = (state_d != IDLE);
        wr_en_d   = (state_d == WRITE);
        done_d    = wr_en_d;
        timeout_d = wr_en_d && abort;
        wr_addr_d = wr_en_d ? 3'b100 : 3'b000;
        wr_data_d = wr_data_q;
        if (wr_en_d) begin
            wr_data_d = abort ? '0 : {high_d, sig_cnt_d, ref_d};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            sync_q    <= '0;
            sig_s_d_q <= 1'b0;
            gt_q      <= '0;
            ref_q     <= '0;
            sig_cnt_q <= '0;
            high_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            sig_s_d_q <= sig_s_d_d;
            gt_q      <= gt_d;
            ref_q     <= ref_d;
            sig_cnt_q <= sig_cnt_d;
            high_q    <= high_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign bus.busy_o        = busy_q;
    assign bus.done_o        = done_q;
    assign bus.timeout_o     = timeout_q;
    assign bus.reg_wr_en_o   = wr_en_q;
    assign bus.reg_wr_addr_o = wr_addr_q;
    assign bus.reg_wr_data_o = wr_data_q;

endmodule

// File: tb/tb_dfm_gate_ctl.sv
// Directed self-checking bench for dfm_gate_ctl; expectations follow the build's
// DFM_TIMEOUT_EN setting.
module tb_dfm_gate_ctl;

    logic clk = 1'b0;
    logic rst;
    logic sig_i;

    dfm_gate_ctl_if bus ();

    dfm_gate_ctl #(.SYNC_STAGES(2), .CNT_WIDTH(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .sig_i (sig_i),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Periodic signal source, changes shortly after the rising edge
    int sig_period = 10;
    int sig_high   = 3;
    bit sig_en     = 1'b0;
    int phase      = 0;

    initial begin
        sig_i = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (sig_en) begin
                phase = (phase + 1 >= sig_period) ? 0 : phase + 1;
                sig_i = (phase < sig_high);
            end else begin
                sig_i = 1'b0;
            end
        end
    end

    // Write-port monitor
    int          cyc = 0;
    int          wr_count = 0;
    int          done_orphan = 0;
    int          busy_rise_cyc = 0;
    int          last_wr_cyc = 0;
    logic        busy_prev = 1'b0;
    logic [95:0] wr_data;
    logic [2:0]  wr_addr;
    logic        wr_done, wr_to;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.reg_wr_en_o === 1'b1) begin
                wr_count++;
                wr_data     = bus.reg_wr_data_o;
                wr_addr     = bus.reg_wr_addr_o;
                wr_done     = bus.done_o;
                wr_to       = bus.timeout_o;
                last_wr_cyc = cyc;
            end
            if (bus.done_o === 1'b1 && bus.reg_wr_en_o !== 1'b1) done_orphan++;
            if (bus.busy_o === 1'b1 && busy_prev !== 1'b1) busy_rise_cyc = cyc;
            busy_prev = bus.busy_o;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [31:0] gate);
        bus.gate_time_i = gate;
        bus.start_i     = 1'b1;
        tick();
        bus.start_i     = 1'b0;
    endtask

    task automatic start_and_wait(input logic [31:0] gate, input int budget, output bit timed_out);
        int base;
        base = wr_count;
        pulse_start(gate);
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (wr_count != base) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int base;
        bit to;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy_o); end
        checks++; if (bus.reg_wr_en_o !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b want 0", bus.reg_wr_en_o); end
        checks++; if (bus.done_o !== 1'b0 || bus.timeout_o !== 1'b0) begin errors++; $display("FAIL reset_done_to got %b%b want 00", bus.done_o, bus.timeout_o); end
        checks++; if (bus.reg_wr_addr_o !== 3'b000) begin errors++; $display("FAIL reset_addr got %b want 000", bus.reg_wr_addr_o); end
        checks++; if (bus.reg_wr_data_o !== 96'h0) begin errors++; $display("FAIL reset_data got %h want 0", bus.reg_wr_data_o); end

        sig_period = 10; sig_high = 3; sig_en = 1'b1;
        repeat (20) tick();
        base = wr_count;
        pulse_start(32'd100);
        repeat (50) tick();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_mid_busy got %b want 0", bus.busy_o); end
        repeat (200) tick();
        checks++; if (wr_count != base) begin errors++; $display("FAIL reset_mid_nowrite got %0d writes want 0", wr_count - base); end

        start_and_wait(32'd100, 400, to);
        checks++; if (to) begin errors++; $display("FAIL reset_fresh_timeout got no write want write"); end
        checks++; if (wr_data !== {32'd30, 32'd10, 32'd100}) begin errors++; $display("FAIL reset_fresh_data got %h want %h", wr_data, {32'd30, 32'd10, 32'd100}); end
    endtask

    task automatic test_basic();
        int base;
        bit to;
        tick();
        base = wr_count;
        start_and_wait(32'd100, 400, to);
        checks++; if (to) begin errors++; $display("FAIL basic_timeout got no write want write"); end
        checks++; if (wr_addr !== 3'b100) begin errors++; $display("FAIL basic_addr got %b want 100", wr_addr); end
        checks++; if (wr_done !== 1'b1 || wr_to !== 1'b0) begin errors++; $display("FAIL basic_done_to got %b%b want 10", wr_done, wr_to); end
        checks++; if (wr_data[31:0] !== 32'd100) begin errors++; $display("FAIL basic_ref got %0d want 100", wr_data[31:0]); end
        checks++; if (wr_data[63:32] !== 32'd10) begin errors++; $display("FAIL basic_sig got %0d want 10", wr_data[63:32]); end
        checks++; if (wr_data[95:64] !== 32'd30) begin errors++; $display("FAIL basic_high got %0d want 30", wr_data[95:64]); end
        tick();
        checks++; if (bus.busy_o !== 1'b0 || bus.reg_wr_en_o !== 1'b0) begin errors++; $display("FAIL basic_after got busy=%b en=%b want 0 0", bus.busy_o, bus.reg_wr_en_o); end
        repeat (50) tick();
        checks++; if (wr_count != base + 1) begin errors++; $display("FAIL basic_single got %0d writes want 1", wr_count - base); end
        checks++; if (done_orphan != 0) begin errors++; $display("FAIL basic_done_orphan got %0d want 0", done_orphan); end
    endtask

    task automatic test_gate_rounding();
        bit to;
        tick();
        start_and_wait(32'd95, 400, to);
        checks++; if (to) begin errors++; $display("FAIL round95_timeout got no write want write"); end
        checks++; if (wr_data[63:0] !== {32'd10, 32'd100}) begin errors++; $display("FAIL round95 got sig=%0d ref=%0d want 10 100", wr_data[63:32], wr_data[31:0]); end
        tick();
        start_and_wait(32'd0, 400, to);
        checks++; if (to) begin errors++; $display("FAIL round0_timeout got no write want write"); end
`ifdef DFM_TIMEOUT_EN
        checks++; if (wr_data !== 96'h0 || wr_to !== 1'b1) begin errors++; $display("FAIL round0 got data=%h to=%b want 0 1", wr_data, wr_to); end
`else
        checks++; if (wr_data[63:0] !== {32'd1, 32'd10} || wr_to !== 1'b0) begin errors++; $display("FAIL round0 got sig=%0d ref=%0d to=%b want 1 10 0", wr_data[63:32], wr_data[31:0], wr_to); end
`endif
    endtask

    task automatic test_ignored_start();
        int base;
        int bad;
        bit got;
        tick();
        base = wr_count;
        bad = 0;
        got = 1'b0;
        pulse_start(32'd100);
        repeat (3) tick();
        pulse_start(32'd5);
        repeat (40) tick();
        pulse_start(32'd5);
        for (int i = 0; i < 300; i++) begin
            if (bus.busy_o !== 1'b1) bad++;
            if (wr_count != base) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        checks++; if (!got || bad != 0) begin errors++; $display("FAIL ign_busy got write=%0d low_cycles=%0d want 1 0", got, bad); end
        repeat (150) tick();
        checks++; if (wr_count != base + 1) begin errors++; $display("FAIL ign_single got %0d writes want 1", wr_count - base); end
        checks++; if (wr_data[63:0] !== {32'd10, 32'd100}) begin errors++; $display("FAIL ign_data got sig=%0d ref=%0d want 10 100", wr_data[63:32], wr_data[31:0]); end
    endtask

    task automatic test_slow();
        bit to;
        sig_period = 40; sig_high = 7;
        repeat (50) tick();
        start_and_wait(32'd1, 300, to);
        checks++; if (to) begin errors++; $display("FAIL slow_timeout got no write want write"); end
`ifdef DFM_TIMEOUT_EN
        checks++; if (wr_data !== 96'h0 || wr_to !== 1'b1) begin errors++; $display("FAIL slow got data=%h to=%b want 0 1", wr_data, wr_to); end
`else
        checks++; if (wr_data !== {32'd7, 32'd1, 32'd40}) begin errors++; $display("FAIL slow got %h want %h", wr_data, {32'd7, 32'd1, 32'd40}); end
`endif
    endtask

    task automatic test_static_signal();
        int base;
        bit to;
        sig_en = 1'b0;
        repeat (10) tick();
        base = wr_count;
`ifdef DFM_TIMEOUT_EN
        start_and_wait(32'd50, 400, to);
        checks++; if (to) begin errors++; $display("FAIL wd_timeout got no write want write"); end
        checks++; if (last_wr_cyc - busy_rise_cyc != 200) begin errors++; $display("FAIL wd_latency got %0d want 200", last_wr_cyc - busy_rise_cyc); end
        checks++; if (wr_data !== 96'h0 || wr_to !== 1'b1 || wr_done !== 1'b1) begin errors++; $display("FAIL wd_result got data=%h to=%b done=%b want 0 1 1", wr_data, wr_to, wr_done); end
`else
        start_and_wait(32'd50, 1000, to);
        checks++; if (!to || wr_count != base) begin errors++; $display("FAIL static_nowrite got %0d writes want 0", wr_count - base); end
        checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL static_busy got %b want 1", bus.busy_o); end
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
`endif
    endtask

    initial begin
        rst = 1'b1;
        bus.start_i = 1'b0;
        bus.gate_time_i = '0;
        test_reset();
        test_basic();
        test_gate_rounding();
        test_ignored_start();
        test_slow();
        test_static_signal();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
